// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Each grant covers a burst of up to MAX_BURST words; one bubble per arbitration.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int REQ_IDX_W  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic [REQ_IDX_W-1:0]          owner
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [REQ_IDX_W-1:0]   owner_r;
    logic [REQ_IDX_W-1:0]   owner_nx;
    logic [REQ_IDX_W-1:0]   owner_inc;
    logic [REQ_IDX_W-1:0]   rr_ptr;
    logic [REQ_IDX_W-1:0]   rr_ptr_nx;
    logic [REQ_IDX_W-1:0]   pick;
    logic [REQ_IDX_W-1:0]   sel;
    logic [CNT_W-1:0]       burst_cnt;
    logic [CNT_W-1:0]       burst_cnt_nx;
    logic [DATA_WIDTH-1:0]  words [NUM_REQ];
    logic                   found;
    logic                   xfer;
    int                     idx;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First active requester at or after rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = idx[REQ_IDX_W-1:0];
            if (!found && req[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    always_comb begin
        if (int'(owner_r) == NUM_REQ - 1) begin
            owner_inc = '0;
        end else begin
            owner_inc = owner_r + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_r   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            owner_r   <= owner_nx;
            rr_ptr    <= rr_ptr_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner_r;
        rr_ptr_nx    = rr_ptr;
        burst_cnt_nx = burst_cnt;
        xfer         = 1'b0;
        gnt          = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_nx     = pick;
                    burst_cnt_nx = '0;
                    state_nx     = BURST;
                end
            end
            BURST: begin
                xfer = req[owner_r] & ~fifo_full;
                if (xfer) begin
                    gnt[owner_r] = 1'b1;
                    fifo_wr_en   = 1'b1;
                    fifo_data_in = words[owner_r];
                end
                // A withdrawn request ends the burst even during a full stall.
                if (!req[owner_r] ||
                    (xfer && burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = owner_inc;
                end else if (xfer) begin
                    burst_cnt_nx = burst_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy  = (state == BURST);
    assign owner = owner_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations
// plus a random run checked every cycle against a burst-level model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  gnt;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data_in;
    logic          busy;
    logic [IW-1:0] owner;

    fifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(N),
        .MAX_BURST(MB),
        .REQ_IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in),
        .busy(busy),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Burst-level model: who owns the write port and how many words remain.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_left = 0;

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 0;
            m_left  <= 0;
        end else if (!m_busy) begin
            if (req != '0) begin
                m_owner <= rr_pick(m_ptr, req);
                m_left  <= MB;
                m_busy  <= 1'b1;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_owner + 1) % N;
        end else if (!fifo_full) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_ptr  <= (m_owner + 1) % N;
            end
        end
    end

    // Requester word queues and write log.
    logic [DW-1:0] qm [N][64];
    int qh [N];
    int qt [N];
    bit [5:0] gseq [N];
    bit rand_mode = 1'b0;
    logic [N-1:0] gnt_q = '0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        int            own;
    } wr_t;
    wr_t wlog [$];
    int wbase = 0;

    int written [N];
    int granted [N];
    bit [5:0] eseq [N];

    task automatic compare_cycle();
        logic [N-1:0]  eg = '0;
        logic [DW-1:0] ed = '0;
        wr_t w;
        if (m_busy && req[m_owner] && !fifo_full) begin
            eg[m_owner] = 1'b1;
            ed = req_data[m_owner*DW +: DW];
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("wr_en", 32'(fifo_wr_en), 32'(|eg));
        chk("data", 32'(fifo_data_in), 32'(ed));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("wr_eq_gnt", 32'(fifo_wr_en), 32'(|gnt));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'(1));
        chk("wr_when_full", 32'(fifo_wr_en & fifo_full), 32'(0));
        if (fifo_wr_en) begin
            w.data = fifo_data_in;
            w.cyc  = cyc;
            w.own  = int'(owner);
            wlog.push_back(w);
            if (rand_mode) begin
                chk("seq", 32'(fifo_data_in[5:0]),
                    32'(eseq[fifo_data_in[7:6]]));
                eseq[fifo_data_in[7:6]] = fifo_data_in[5:0] + 6'd1;
                written[fifo_data_in[7:6]]++;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) granted[i]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            gnt_q <= '0;
        end else begin
            compare_cycle();
            gnt_q <= gnt;
        end
    end

    task automatic push(input int i, input logic [DW-1:0] v);
        qm[i][qt[i] % 64] = v;
        qt[i]++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i] && qh[i] != qt[i]) qh[i]++;
            if (rand_mode && qh[i] == qt[i] && $urandom_range(0, 2) == 0) begin
                push(i, {2'(i), gseq[i]});
                gseq[i] = gseq[i] + 6'd1;
            end
            if (qh[i] != qt[i]) begin
                req[i] = 1'b1;
                req_data[i*DW +: DW] = qm[i][qh[i] % 64];
            end else begin
                req[i] = 1'b0;
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        fifo_full = 1'b0;
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wbase = wlog.size();
    endtask

    function automatic int nw();
        return wlog.size() - wbase;
    endfunction

    function automatic wr_t wl(input int k);
        wr_t z;
        z.data = '0;
        z.cyc  = 0;
        z.own  = -1;
        if (k < nw()) return wlog[wbase + k];
        return z;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (qh[i] != qt[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;

        // Reset values while rst_n is low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_owner", 32'(owner), 32'(0));

        // Sole requester: 4-word burst, bubble, remaining 2 words.
        do_reset();
        for (int v = 1; v <= 6; v++) push(0, DW'(v));
        repeat (12) step();
        chk("t1_count", 32'(nw()), 32'(6));
        for (int k = 0; k < 6; k++) begin
            w = wl(k);
            chk("t1_data", 32'(w.data), 32'(k + 1));
            chk("t1_owner", 32'(w.own), 32'(0));
        end
        chk("t1_run", 32'(wl(3).cyc - wl(0).cyc), 32'(3));
        chk("t1_bubble", 32'(wl(4).cyc - wl(3).cyc), 32'(2));
        chk("t1_tail", 32'(wl(5).cyc - wl(4).cyc), 32'(1));

        // All four requesting: bursts of 4 in order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < 8; s++) push(i, {2'(i), 6'(s)});
        end
        for (int t = 0; t < 100 && !all_empty(); t++) step();
        chk("t2_drain", 32'(all_empty()), 32'(1));
        chk("t2_count", 32'(nw()), 32'(32));
        for (int k = 0; k < 32; k++) begin
            w = wl(k);
            chk("t2_id", 32'(w.data[7:6]), 32'((k / 4) % 4));
            chk("t2_seq", 32'(w.data[5:0]), 32'((k / 16) * 4 + k % 4));
        end

        // Full stall for 3 cycles after word 2 of owner 2's burst.
        do_reset();
        for (int s = 1; s <= 4; s++) push(2, DW'(8'h20 + s));
        for (int t = 0; t < 20 && nw() < 2; t++) step();
        chk("t3_start", 32'(nw()), 32'(2));
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_wr", 32'(fifo_wr_en), 32'(0));
            chk("t3_stall_gnt", 32'(gnt), 32'(0));
            chk("t3_stall_busy", 32'(busy), 32'(1));
            step();
        end
        fifo_full = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t3_end_busy", 32'(busy), 32'(0));
        chk("t3_count", 32'(nw()), 32'(4));
        chk("t3_w3", 32'(wl(2).data), 32'(8'h23));
        chk("t3_w4", 32'(wl(3).data), 32'(8'h24));
        chk("t3_gap", 32'(wl(2).cyc - wl(1).cyc), 32'(4));

        // Owner 1 withdraws after 2 words; requester 3 takes over.
        do_reset();
        push(1, 8'h11);
        push(1, 8'h12);
        push(3, 8'h31);
        push(3, 8'h32);
        repeat (12) step();
        chk("t4_count", 32'(nw()), 32'(4));
        chk("t4_w0", 32'(wl(0).data), 32'(8'h11));
        chk("t4_w1", 32'(wl(1).data), 32'(8'h12));
        chk("t4_w2", 32'(wl(2).data), 32'(8'h31));
        chk("t4_gap", 32'(wl(2).cyc - wl(1).cyc), 32'(3));
        chk("t4_owner", 32'(wl(2).own), 32'(3));

        // Async reset between edges during owner 2's burst.
        do_reset();
        for (int s = 0; s < 8; s++) push(2, DW'(8'h40 + s));
        for (int t = 0; t < 20 && nw() < 2; t++) step();
        chk("t5_owner_pre", 32'(owner), 32'(2));
        chk("t5_wr_pre", 32'(fifo_wr_en), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("t5_gnt", 32'(gnt), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_owner", 32'(owner), 32'(0));
        do_reset();
        push(0, 8'h51);
        push(2, 8'h52);
        for (int t = 0; t < 20 && nw() < 1; t++) step();
        chk("t5_restart_cnt", 32'(nw() >= 1), 32'(1));
        chk("t5_restart_owner", 32'(wl(0).own), 32'(0));
        chk("t5_restart_data", 32'(wl(0).data), 32'(8'h51));

        // Random traffic with random full stalls.
        do_reset();
        rand_mode = 1'b1;
        repeat (2000) begin
            step();
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("t6_written_eq_granted", 32'(written[i]), 32'(granted[i]));
            chk("t6_progress", 32'(granted[i] > 0), 32'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
